controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller_pkg.sv | 131 +++++++++++++
 rtl/controller_alucontrol.sv | 39 +++
 rtl/controller.sv | 113 +++++++++++
 tb/tb_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// -----------------------------------------------------------------------------
// controller_pkg
// Shared definitions for the multicycle MIPS-style controller:
//   - state_t   : FSM state encoding
//   - OP_*      : instruction opcodes (IR[31:26])
//   - FN_*      : R-type function codes (IR[5:0])
//   - aluop_t   : internal ALU operation class passed to alucontrol
//   - ALUC_*    : alucont encodings driven to the ALU
//   - ctrl_t    : bundle of all state-decoded datapath controls
//   - state_ctrl: state -> control bundle decode (pure function of state)
// -----------------------------------------------------------------------------
package controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH1  = 4'd0,
      S_FETCH2  = 4'd1,
      S_FETCH3  = 4'd2,
      S_FETCH4  = 4'd3,
      S_DECODE  = 4'd4,
      S_MEMADR  = 4'd5,
      S_LBRD    = 4'd6,
      S_LBWR    = 4'd7,
      S_SBWR    = 4'd8,
      S_RTYPEEX = 4'd9,
      S_RTYPEWR = 4'd10,
      S_BEQEX   = 4'd11,
      S_JEX     = 4'd12,
      S_ADDIEX  = 4'd13,
      S_ADDIWR  = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation class. ALUOP_NONE marks states that use no ALU operation,
   // where alucont must read as all-zero.
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_NONE  = 2'b11
   } aluop_t;

   localparam logic [2:0] ALUC_ADD  = 3'b010;
   localparam logic [2:0] ALUC_SUB  = 3'b110;
   localparam logic [2:0] ALUC_AND  = 3'b000;
   localparam logic [2:0] ALUC_OR   = 3'b001;
   localparam logic [2:0] ALUC_SLT  = 3'b111;
   localparam logic [2:0] ALUC_BAD  = 3'b101;
   localparam logic [2:0] ALUC_IDLE = 3'b000;

   typedef struct packed {
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       branch;
      logic       iord;
      logic [3:0] irwrite;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       regdst;
      logic       pcwrite;
      logic [1:0] pcsource;
      aluop_t     aluop;
   } ctrl_t;

   // Moore decode: every control not explicitly raised for a state stays 0.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c       = '0;
      c.aluop = ALUOP_NONE;
      case (s)
         S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
            c.irwrite = 4'b0001 << s[1:0];
            c.alusrcb = 2'b01;
            c.pcwrite = 1'b1;
            c.aluop   = ALUOP_ADD;
         end
         S_DECODE: begin
            c.alusrcb = 2'b11;
            c.aluop   = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.aluop   = ALUOP_ADD;
         end
         S_LBRD: c.iord = 1'b1;
         S_LBWR: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         S_SBWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWR: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         S_BEQEX: begin
            c.alusrca  = 1'b1;
            c.branch   = 1'b1;
            c.pcsource = 2'b01;
            c.aluop    = ALUOP_SUB;
         end
         S_JEX: begin
            c.pcwrite  = 1'b1;
            c.pcsource = 2'b10;
         end
         S_ADDIWR: c.regwrite = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/controller_alucontrol.sv
// -----------------------------------------------------------------------------
// alucontrol
// Maps the ALU operation class and the R-type funct field to the 3-bit ALU
// control code.
// Ports:
//   aluop   in  2  operation class (controller_pkg::aluop_t encoding)
//   funct   in  6  R-type function field IR[5:0]
//   alucont out 3  ALU operation code
// -----------------------------------------------------------------------------
module alucontrol
   import controller_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucont
);

   // NOTE: give every always_comb output a default first; a path that leaves it
   // unassigned would infer a latch.
   always_comb begin
      alucont = ALUC_IDLE;
      case (aluop)
         ALUOP_ADD:   alucont = ALUC_ADD;
         ALUOP_SUB:   alucont = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucont = ALUC_ADD;
               FN_SUB:  alucont = ALUC_SUB;
               FN_AND:  alucont = ALUC_AND;
               FN_OR:   alucont = ALUC_OR;
               FN_SLT:  alucont = ALUC_SLT;
               default: alucont = ALUC_BAD;
            endcase
         end
         default:     alucont = ALUC_IDLE;
      endcase
   end

endmodule

// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
// Moore FSM sequencing a multicycle datapath through byte-wise instruction
// fetch, decode and per-instruction execute/writeback states.
// Ports:
//   clk       in   1  clock, rising edge
//   reset     in   1  asynchronous, active-low; forces FETCH1
//   op        in   6  opcode IR[31:26]
//   funct     in   6  R-type function IR[5:0]
//   alusrca   out  1  ALU A select (0 PC, 1 reg A)
//   alusrcb   out  2  ALU B select
//   branch    out  1  conditional PC write on ALU zero
//   iord      out  1  memory address select (0 PC, 1 ALUOut)
//   irwrite   out  4  instruction register byte enables
//   memwrite, memtoreg, regwrite, regdst, pcwrite  out 1 each
//   pcsource  out  2  next-PC select
//   alucont   out  3  ALU operation
// Controls are registered alongside the state so they come straight from
// flops; only alucont mixes in the live funct field for RTYPEEX.
// -----------------------------------------------------------------------------
module controller
   import controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       branch,
   output logic       iord,
   output logic [3:0] irwrite,
   output logic       memwrite,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       regdst,
   output logic       pcwrite,
   output logic [1:0] pcsource,
   output logic [2:0] alucont
);

   state_t state_q, state_d;
   ctrl_t  ctrl_q,  ctrl_d;

   // Next-state logic; op is consulted only in DECODE and MEMADR.
   always_comb begin
      state_d = S_FETCH1;
      case (state_q)
         S_FETCH1: state_d = S_FETCH2;
         S_FETCH2: state_d = S_FETCH3;
         S_FETCH3: state_d = S_FETCH4;
         S_FETCH4: state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LB, OP_SB: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_J:         state_d = S_JEX;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_FETCH1;
            endcase
         end
         // An opcode that changed to neither LB nor SB by MEMADR abandons the
         // instruction rather than inventing a path.
         S_MEMADR: begin
            if (op == OP_LB)      state_d = S_LBRD;
            else if (op == OP_SB) state_d = S_SBWR;
            else                  state_d = S_FETCH1;
         end
         S_LBRD:    state_d = S_LBWR;
         S_RTYPEEX: state_d = S_RTYPEWR;
         S_ADDIEX:  state_d = S_ADDIWR;
         default:   state_d = S_FETCH1;
      endcase
   end

   // Controls are decoded from the next state and registered with it, which
   // keeps them a pure function of the current state at the outputs.
   always_comb begin
      ctrl_d = state_ctrl(state_d);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH1;
         ctrl_q  <= state_ctrl(S_FETCH1);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign alusrca  = ctrl_q.alusrca;
   assign alusrcb  = ctrl_q.alusrcb;
   assign branch   = ctrl_q.branch;
   assign iord     = ctrl_q.iord;
   assign irwrite  = ctrl_q.irwrite;
   assign memwrite = ctrl_q.memwrite;
   assign memtoreg = ctrl_q.memtoreg;
   assign regwrite = ctrl_q.regwrite;
   assign regdst   = ctrl_q.regdst;
   assign pcwrite  = ctrl_q.pcwrite;
   assign pcsource = ctrl_q.pcsource;

   alucontrol u_alucontrol (
      .aluop   (ctrl_q.aluop),
      .funct   (funct),
      .alucont (alucont)
   );

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller
// Self-checking bench for controller. The reference model describes each
// instruction as a sequence of steps counted from FETCH1 entry, with the
// expected datapath controls for each step.
// -----------------------------------------------------------------------------
module tb_controller;

   typedef struct packed {
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       branch;
      logic       iord;
      logic [3:0] irwrite;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       regdst;
      logic       pcwrite;
      logic [1:0] pcsource;
      logic [2:0] alucont;
   } outs_t;

   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] LB   = 6'b100000;
   localparam logic [5:0] SB   = 6'b101000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] ADDI = 6'b001000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] op = '0;
   logic [5:0] funct = '0;
   logic       alusrca, branch, iord, memwrite, memtoreg, regwrite, regdst, pcwrite;
   logic [1:0] alusrcb, pcsource;
   logic [3:0] irwrite;
   logic [2:0] alucont;
   outs_t      dut_o;

   int checks = 0;
   int errors = 0;
   int k_start = 0;

   always #5 clk = ~clk;

   controller dut (
      .clk      (clk),
      .reset    (reset),
      .op       (op),
      .funct    (funct),
      .alusrca  (alusrca),
      .alusrcb  (alusrcb),
      .branch   (branch),
      .iord     (iord),
      .irwrite  (irwrite),
      .memwrite (memwrite),
      .memtoreg (memtoreg),
      .regwrite (regwrite),
      .regdst   (regdst),
      .pcwrite  (pcwrite),
      .pcsource (pcsource),
      .alucont  (alucont)
   );

   assign dut_o = {alusrca, alusrcb, branch, iord, irwrite, memwrite, memtoreg,
                   regwrite, regdst, pcwrite, pcsource, alucont};

   task automatic check(input outs_t obs, input outs_t exp, input string tag);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] funct_code(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b101;
      endcase
   endfunction

   function automatic int latency(input logic [5:0] iop);
      case (iop)
         LB:            return 8;
         SB, RT, ADDI:  return 7;
         BEQ, JMP:      return 6;
         default:       return 5;
      endcase
   endfunction

   // Expected controls for step k (0 = FETCH1 entry) of an instruction.
   function automatic outs_t model(input logic [5:0] iop, input logic [5:0] ifn, input int k);
      outs_t e;
      e = '0;
      if (k < 4) begin
         e.irwrite = 4'(1 << k);
         e.alusrcb = 2'b01;
         e.pcwrite = 1'b1;
         e.alucont = 3'b010;
      end else if (k == 4) begin
         e.alusrcb = 2'b11;
         e.alucont = 3'b010;
      end else begin
         case (iop)
            LB, SB: begin
               if (k == 5) begin
                  e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucont = 3'b010;
               end else if (k == 6) begin
                  e.iord = 1'b1;
                  e.memwrite = (iop == SB);
               end else begin
                  e.regwrite = 1'b1; e.memtoreg = 1'b1;
               end
            end
            RT: begin
               if (k == 5) begin
                  e.alusrca = 1'b1; e.alucont = funct_code(ifn);
               end else begin
                  e.regwrite = 1'b1; e.regdst = 1'b1;
               end
            end
            BEQ: begin
               e.alusrca = 1'b1; e.alucont = 3'b110;
               e.branch = 1'b1; e.pcsource = 2'b01;
            end
            JMP: begin
               e.pcwrite = 1'b1; e.pcsource = 2'b10;
            end
            ADDI: begin
               if (k == 5) begin
                  e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucont = 3'b010;
               end else begin
                  e.regwrite = 1'b1;
               end
            end
            default: ;
         endcase
      end
      return e;
   endfunction

   // Runs one instruction from step k_start. Inputs are random except where
   // the controller is allowed to look at them; abort_at >= 0 pulses reset
   // mid-cycle during that step, after which the next instruction resumes
   // at FETCH2.
   task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                            input int abort_at, input string tag);
      for (int k = k_start; k < latency(iop); k++) begin
         @(negedge clk);
         if (k == 4 || (k == 5 && (iop == LB || iop == SB))) op = iop;
         else                                                 op = 6'($urandom);
         if (k == 5 && iop == RT) funct = ifn;
         else                     funct = 6'($urandom);
         #1;
         check(dut_o, model(iop, ifn, k), $sformatf("%s op=%b fn=%b step%0d", tag, iop, ifn, k));
         if (k == abort_at) begin
            #1 reset = 1'b0;
            #1 check(dut_o, model(iop, ifn, 0), $sformatf("%s abort step%0d", tag, k));
            #1 reset = 1'b1;
            k_start = 1;
            return;
         end
      end
      k_start = 0;
   endtask

   function automatic logic [5:0] rand_op();
      logic [5:0] o;
      case ($urandom_range(6, 0))
         0: o = RT;
         1: o = LB;
         2: o = SB;
         3: o = BEQ;
         4: o = JMP;
         5: o = ADDI;
         default: begin
            o = 6'($urandom);
            while (o == RT || o == LB || o == SB || o == BEQ || o == JMP || o == ADDI)
               o = 6'($urandom);
         end
      endcase
      return o;
   endfunction

   function automatic logic [5:0] rand_funct();
      logic [5:0] t [5];
      t = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      if ($urandom_range(5, 0) == 5) return 6'($urandom);
      return t[$urandom_range(4, 0)];
   endfunction

   initial begin
      logic [5:0] d_op [12];
      logic [5:0] d_fn [12];
      d_op = '{LB, SB, RT, RT, RT, RT, RT, RT, BEQ, JMP, ADDI, 6'b111111};
      d_fn = '{6'h00, 6'h00, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
               6'b101010, 6'b110011, 6'h00, 6'h00, 6'h00, 6'h00};

      // Reset held across clock edges keeps FETCH1.
      repeat (3) begin
         @(negedge clk);
         op = 6'($urandom);
         #1 check(dut_o, model(RT, 6'h00, 0), "reset_hold");
      end
      @(posedge clk);
      #1 reset = 1'b1;

      // Directed pass over every opcode and funct code.
      for (int i = 0; i < 12; i++)
         run_instr(d_op[i], d_fn[i], -1, "directed");

      // Directed aborts in late states.
      run_instr(LB, 6'h00, 6, "abort_lbrd");
      run_instr(RT, 6'b100100, 5, "abort_rtypeex");
      run_instr(BEQ, 6'h00, -1, "after_abort");

      // Randomized instruction stream with occasional mid-instruction reset.
      for (int n = 0; n < 300; n++) begin
         logic [5:0] r_op;
         int         ab;
         r_op = rand_op();
         ab   = ($urandom_range(15, 0) == 0) ? $urandom_range(latency(r_op) - 1, 1) : -1;
         run_instr(r_op, rand_funct(), ab, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
